// File: rtl/priority_resolver_isr_if.sv
// priority_resolver_isr_if
// Bundles the request/acknowledge/EOI inputs and the CPU/IRR/data-bus outputs
// of priority_resolver_isr.
//   master : drives IRR, IMR, INTA, EOI and mode inputs; observes the outputs
//   slave  : the resolver itself
interface priority_resolver_isr_if;
  logic [7:0] interrupt_req_reg;
  logic [7:0] interrupt_mask;
  logic       inta_n;
  logic       eoi;
  logic       specific_eoi;
  logic [2:0] eoi_level;
  logic       rotate_en;
  logic       auto_eoi;
  logic [4:0] vector_base;
  logic       int_out;
  logic [7:0] clear_ir_line;
  logic [7:0] in_service_reg;
  logic [7:0] data_out;
  logic       data_out_en;

  modport master (
    output interrupt_req_reg, interrupt_mask, inta_n, eoi, specific_eoi,
           eoi_level, rotate_en, auto_eoi, vector_base,
    input  int_out, clear_ir_line, in_service_reg, data_out, data_out_en
  );

  modport slave (
    input  interrupt_req_reg, interrupt_mask, inta_n, eoi, specific_eoi,
           eoi_level, rotate_en, auto_eoi, vector_base,
    output int_out, clear_ir_line, in_service_reg, data_out, data_out_en
  );
endinterface

// File: rtl/priority_resolver_isr.sv
// priority_resolver_isr
// Picks the highest-priority unmasked pending IR line (rotating priority,
// fully nested against the ISR), runs the two-pulse INTA sequence, commits the
// winner to the ISR, pulses the IRR clear line, drives the vector byte and
// retires ISR bits on EOI / automatic EOI.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave modport of priority_resolver_isr_if
//           (IRR, IMR, inta_n, EOI controls, mode, vector base in;
//            int_out, clear_ir_line, in_service_reg, data_out, data_out_en out)
module priority_resolver_isr (
  input logic                    clk,
  input logic                    rst_n,
  priority_resolver_isr_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACK1 = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;
  localparam logic [1:0] ST_ACK2 = 2'd3;

  logic [1:0] state;
  logic       inta_n_q;
  logic [2:0] lowest;
  logic [7:0] isr;
  logic [2:0] win_q;
  logic       spurious_q;
  logic       int_out_q;
  logic [7:0] clear_q;
  logic [7:0] dout_q;
  logic       dout_en_q;

  logic       inta_fall;
  logic       inta_rise;
  logic       ack_start;
  logic       ack2_end;

  logic [7:0] cand;
  logic       cand_found;
  logic [2:0] cand_idx;
  logic [3:0] cand_pos;
  logic       isr_found;
  logic [2:0] isr_idx;
  logic [3:0] isr_pos;
  logic       win_valid;

  logic [7:0] isr_nx;
  logic [2:0] lowest_nx;

  assign inta_fall = !bus.inta_n && inta_n_q;
  assign inta_rise = bus.inta_n && !inta_n_q;
  assign ack_start = (state == ST_IDLE) && inta_fall;
  assign ack2_end  = (state == ST_ACK2) && inta_rise;

  // Walk the priority ring starting just above 'lowest'; position 1 is the
  // highest priority. The winner must sit strictly ahead of the first ISR bit.
  always_comb begin
    logic [2:0] idx;
    idx        = '0;
    cand       = bus.interrupt_req_reg & ~bus.interrupt_mask;
    cand_found = 1'b0;
    cand_idx   = '0;
    cand_pos   = '0;
    isr_found  = 1'b0;
    isr_idx    = '0;
    isr_pos    = '0;
    for (int unsigned i = 1; i <= 8; i++) begin
      idx = lowest + 3'(i);
      if (cand[idx] && !cand_found) begin
        cand_found = 1'b1;
        cand_idx   = idx;
        cand_pos   = 4'(i);
      end
      if (isr[idx] && !isr_found) begin
        isr_found = 1'b1;
        isr_idx   = idx;
        isr_pos   = 4'(i);
      end
    end
    win_valid = cand_found && (!isr_found || (cand_pos < isr_pos));
  end

  // ISR / rotation next state: clears (AEOI, then EOI) precede the new set, so
  // a same-bit EOI and set in one cycle leaves the bit set.
  always_comb begin
    isr_nx    = isr;
    lowest_nx = lowest;
    if (ack2_end && bus.auto_eoi && !spurious_q) begin
      isr_nx[win_q] = 1'b0;
      if (bus.rotate_en) lowest_nx = win_q;
    end
    if (bus.eoi) begin
      if (bus.specific_eoi) begin
        isr_nx[bus.eoi_level] = 1'b0;
        if (bus.rotate_en) lowest_nx = bus.eoi_level;
      end else if (isr_found) begin
        isr_nx[isr_idx] = 1'b0;
        if (bus.rotate_en) lowest_nx = isr_idx;
      end
    end
    if (ack_start && win_valid) isr_nx[cand_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      inta_n_q   <= 1'b1;
      lowest     <= 3'd7;
      isr        <= '0;
      win_q      <= '0;
      spurious_q <= 1'b0;
      int_out_q  <= 1'b0;
      clear_q    <= '0;
      dout_q     <= '0;
      dout_en_q  <= 1'b0;
    end else begin
      inta_n_q  <= bus.inta_n;
      isr       <= isr_nx;
      lowest    <= lowest_nx;
      int_out_q <= (state == ST_IDLE) && !inta_fall && win_valid;
      clear_q   <= (ack_start && win_valid) ? (8'd1 << cand_idx) : '0;

      case (state)
        ST_IDLE: begin
          if (inta_fall) begin
            win_q      <= win_valid ? cand_idx : 3'd7;
            spurious_q <= !win_valid;
            state      <= ST_ACK1;
          end
        end
        ST_ACK1: begin
          if (inta_rise) state <= ST_GAP;
        end
        ST_GAP: begin
          if (inta_fall) begin
            state     <= ST_ACK2;
            dout_en_q <= 1'b1;
            dout_q    <= {bus.vector_base, win_q};
          end
        end
        default: begin
          if (inta_rise) begin
            state     <= ST_IDLE;
            dout_en_q <= 1'b0;
            dout_q    <= '0;
          end else begin
            dout_q <= {bus.vector_base, win_q};
          end
        end
      endcase
    end
  end

  assign bus.int_out        = int_out_q;
  assign bus.clear_ir_line  = clear_q;
  assign bus.in_service_reg = isr;
  assign bus.data_out       = dout_q;
  assign bus.data_out_en    = dout_en_q;

endmodule

// File: tb/tb_priority_resolver_isr.sv
module tb_priority_resolver_isr;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  // reference state
  logic [7:0] m_isr;
  int         m_lowest;

  priority_resolver_isr_if bus();

  priority_resolver_isr dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Rank 0 = highest priority: the line just after 'lowest' in the ring.
  function automatic int rank(input int idx, input int low);
    return (((idx - low - 1) % 8) + 8) % 8;
  endfunction

  function automatic int best(input logic [7:0] vec, input int low);
    int b;
    b = -1;
    for (int k = 0; k < 8; k++)
      if (vec[k] && (b < 0 || rank(k, low) < rank(b, low))) b = k;
    return b;
  endfunction

  function automatic int model_winner();
    int w;
    int h;
    w = best(bus.interrupt_req_reg & ~bus.interrupt_mask, m_lowest);
    if (w < 0) return -1;
    h = best(m_isr, m_lowest);
    if (h >= 0 && rank(w, m_lowest) >= rank(h, m_lowest)) return -1;
    return w;
  endfunction

  task automatic m_eoi(input bit spec, input logic [2:0] lvl, input bit rot);
    int h;
    if (spec) begin
      m_isr[lvl] = 1'b0;
      if (rot) m_lowest = int'(lvl);
    end else begin
      h = best(m_isr, m_lowest);
      if (h >= 0) begin
        m_isr[h] = 1'b0;
        if (rot) m_lowest = h;
      end
    end
  endtask

  task automatic check_int_out(input string tag);
    chk(tag, {7'd0, bus.int_out}, {7'd0, (model_winner() >= 0)});
  endtask

  task automatic eoi_cmd(input bit spec, input logic [2:0] lvl, input bit rot);
    bus.eoi          = 1'b1;
    bus.specific_eoi = spec;
    bus.eoi_level    = lvl;
    bus.rotate_en    = rot;
    tick();
    bus.eoi = 1'b0;
    m_eoi(spec, lvl, rot);
    chk("eoi_isr", bus.in_service_reg, m_isr);
  endtask

  // Full two-pulse INTA sequence, optionally with an EOI strobe in the same
  // cycle as the first falling edge.
  task automatic inta_seq(input logic [4:0] base, input bit aeoi, input bit rot,
                          input bit eoi_f, input bit spec_f, input logic [2:0] lvl_f);
    int         w;
    logic [2:0] wv;
    logic [7:0] exp_clr;
    bus.vector_base = base;
    bus.auto_eoi    = aeoi;
    bus.rotate_en   = rot;
    w  = model_winner();
    wv = (w < 0) ? 3'd7 : 3'(w);
    bus.inta_n       = 1'b0;
    bus.eoi          = eoi_f;
    bus.specific_eoi = spec_f;
    bus.eoi_level    = lvl_f;
    tick();
    bus.eoi = 1'b0;
    if (eoi_f) m_eoi(spec_f, lvl_f, rot);
    exp_clr = '0;
    if (w >= 0) begin
      m_isr[w]   = 1'b1;
      exp_clr[w] = 1'b1;
    end
    chk("ack1_clear", bus.clear_ir_line, exp_clr);
    chk("ack1_isr", bus.in_service_reg, m_isr);
    chk("ack1_int_out", {7'd0, bus.int_out}, 8'd0);
    tick();
    chk("ack1_clear_done", bus.clear_ir_line, 8'd0);
    bus.inta_n = 1'b1;
    tick();
    tick();
    chk("gap_isr", bus.in_service_reg, m_isr);
    chk("gap_en", {7'd0, bus.data_out_en}, 8'd0);
    chk("gap_int_out", {7'd0, bus.int_out}, 8'd0);
    bus.inta_n = 1'b0;
    tick();
    chk("ack2_data", bus.data_out, {base, wv});
    chk("ack2_en", {7'd0, bus.data_out_en}, 8'd1);
    tick();
    chk("ack2_en_hold", {7'd0, bus.data_out_en}, 8'd1);
    bus.inta_n = 1'b1;
    tick();
    if (aeoi && w >= 0) begin
      m_isr[w] = 1'b0;
      if (rot) m_lowest = w;
    end
    chk("end_en", {7'd0, bus.data_out_en}, 8'd0);
    chk("end_data", bus.data_out, 8'd0);
    chk("end_isr", bus.in_service_reg, m_isr);
    tick();
    if (w >= 0) bus.interrupt_req_reg[w] = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_isr    = '0;
    m_lowest = 7;
    rst_n                 = 1'b0;
    bus.interrupt_req_reg = '0;
    bus.interrupt_mask    = '0;
    bus.inta_n            = 1'b1;
    bus.eoi               = 1'b0;
    bus.specific_eoi      = 1'b0;
    bus.eoi_level         = '0;
    bus.rotate_en         = 1'b0;
    bus.auto_eoi          = 1'b0;
    bus.vector_base       = '0;
    tick();
    tick();
    chk("rst_int_out", {7'd0, bus.int_out}, 8'd0);
    chk("rst_clear", bus.clear_ir_line, 8'd0);
    chk("rst_isr", bus.in_service_reg, 8'd0);
    chk("rst_data", bus.data_out, 8'd0);
    chk("rst_en", {7'd0, bus.data_out_en}, 8'd0);
    rst_n = 1'b1;
    tick();

    // basic grant: IR3 beats IR5
    bus.interrupt_req_reg = 8'h28;
    tick();
    check_int_out("t1_int_out");
    chk("t1_int_out_const", {7'd0, bus.int_out}, 8'd1);
    inta_seq(5'h08, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    chk("t1_isr_const", bus.in_service_reg, 8'h08);

    // fully nested blocking
    eoi_cmd(1'b1, 3'd3, 1'b0);
    bus.interrupt_req_reg = 8'h04;
    tick();
    check_int_out("t2_int_out_a");
    inta_seq(5'h08, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    chk("t2_isr_04", bus.in_service_reg, 8'h04);
    bus.interrupt_req_reg = 8'h10;
    tick();
    check_int_out("t2_blocked");
    chk("t2_blocked_const", {7'd0, bus.int_out}, 8'd0);
    bus.interrupt_req_reg = 8'h02;
    tick();
    check_int_out("t2_int_out_b");
    inta_seq(5'h08, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    chk("t2_isr_06", bus.in_service_reg, 8'h06);

    // non-specific EOI with rotation, then IR7 outranks IR0
    eoi_cmd(1'b0, 3'd0, 1'b1);
    chk("t3_isr_04", bus.in_service_reg, 8'h04);
    eoi_cmd(1'b0, 3'd0, 1'b0);
    bus.interrupt_req_reg = 8'h81;
    tick();
    check_int_out("t3_int_out");
    inta_seq(5'h08, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    chk("t3_isr_80", bus.in_service_reg, 8'h80);
    eoi_cmd(1'b1, 3'd7, 1'b1);

    // automatic EOI
    bus.interrupt_req_reg = 8'h01;
    tick();
    check_int_out("t4_int_out");
    inta_seq(5'h08, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    chk("t4_isr_after", bus.in_service_reg, 8'h00);
    bus.auto_eoi = 1'b0;

    // spurious acknowledge
    bus.interrupt_req_reg = 8'h08;
    tick();
    check_int_out("t5_int_out_a");
    bus.interrupt_req_reg = 8'h00;
    tick();
    check_int_out("t5_int_out_b");
    inta_seq(5'h08, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    chk("t5_isr", bus.in_service_reg, 8'h00);

    // same-bit EOI and set in one cycle: set wins
    bus.interrupt_req_reg = 8'h20;
    tick();
    inta_seq(5'h11, 1'b0, 1'b0, 1'b1, 1'b1, 3'd5);
    chk("t6_isr_set_wins", bus.in_service_reg, 8'h20);
    eoi_cmd(1'b1, 3'd5, 1'b0);

    // asynchronous reset in GAP
    bus.interrupt_req_reg = 8'h10;
    tick();
    bus.inta_n = 1'b0;
    tick();
    tick();
    bus.inta_n = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    #2;
    chk("t7_rst_isr", bus.in_service_reg, 8'h00);
    chk("t7_rst_int_out", {7'd0, bus.int_out}, 8'd0);
    chk("t7_rst_clear", bus.clear_ir_line, 8'd0);
    chk("t7_rst_data", bus.data_out, 8'd0);
    chk("t7_rst_en", {7'd0, bus.data_out_en}, 8'd0);
    rst_n    = 1'b1;
    m_isr    = '0;
    m_lowest = 7;
    tick();
    check_int_out("t7_int_out");
    inta_seq(5'h1f, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    chk("t7_isr_fresh", bus.in_service_reg, 8'h10);

    // randomized traffic against the reference model
    for (int it = 0; it < 60; it++) begin
      bus.interrupt_req_reg = 8'($urandom);
      bus.interrupt_mask    = 8'($urandom) & 8'($urandom);
      tick();
      check_int_out("rnd_int_out");
      if ($urandom_range(0, 2) != 0)
        inta_seq(5'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 3) == 0), 1'($urandom), 3'($urandom));
      else
        eoi_cmd(1'($urandom), 3'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/priority_resolver_isr.md
# priority_resolver_isr

Resolves the highest-priority unmasked pending interrupt from the interrupt request register and maintains the in-service register (ISR). Runs the two-pulse 8086-mode INTA sequence: it raises `int_out`, commits the winner to ISR, and pulses `clear_ir_line` back to the IRR. It then drives the vector byte and retires ISR bits on EOI or automatic EOI. It sits directly downstream of the IRR and upstream of the data-bus buffer.

## Interface
- No parameters; width fixed at 8 IR lines.
- `clk` in 1: system clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `interrupt_req_reg` in 8: pending requests from the IRR.
- `interrupt_mask` in 8: IMR; 1 = line masked.
- `inta_n` in 1: CPU interrupt acknowledge, active low, synchronous to `clk`.
- `eoi` in 1: one-cycle EOI command strobe.
- `specific_eoi` in 1: qualifies `eoi`; 1 = specific, 0 = non-specific.
- `eoi_level` in 3: level cleared by a specific EOI.
- `rotate_en` in 1: EOI (or AEOI) also rotates priority.
- `auto_eoi` in 1: AEOI mode.
- `vector_base` in 5: T7..T3 of the vector.
- `int_out` out 1: interrupt request to the CPU.
- `clear_ir_line` out 8: one-hot, one-cycle clear pulse to the IRR.
- `in_service_reg` out 8: ISR.
- `data_out` out 8: vector byte.
- `data_out_en` out 1: vector valid and bus drive enable.

## Operation
- Priority pointer `lowest` (3 bits, reset 7).
  - Priority order is `lowest+1`, `lowest+2`, …, `lowest` (mod 8).
  - With `lowest=7`, IR0 is highest.
- Candidate set is `interrupt_req_reg & ~interrupt_mask`.
  - Winner = highest-priority candidate.
  - Winner is valid only if it has strictly higher priority than the highest set ISR bit (fully nested; an equal or lower level is blocked).
- State machine:
  - IDLE: wait for an `inta_n` falling edge, i.e. `inta_n` low while the registered `inta_n_q` is high.
    - Latch winner `W`. If none is valid (spurious), latch `W=7` and set no ISR bit.
    - Otherwise set ISR[W] and drive `clear_ir_line[W]`=1 for exactly one cycle.
    - Go to ACK1.
  - ACK1: on `inta_n` rising edge, go to GAP.
  - GAP: on `inta_n` falling edge, go to ACK2.
  - ACK2: `data_out={vector_base,W}`, `data_out_en`=1 for as long as `inta_n` is low.
    - On `inta_n` rising edge, go to IDLE.
    - If `auto_eoi`, clear ISR[W] in that cycle, skipped for a spurious `W`.
    - If also `rotate_en`, set `lowest:=W`.
- EOI, accepted in any state:
  - Non-specific: clear the highest-priority set ISR bit; if `rotate_en`, set `lowest` to that bit. No effect if ISR=0.
  - Specific: clear ISR[`eoi_level`]; if `rotate_en`, set `lowest:=eoi_level`.
- EOI in the same cycle as an ISR set: the EOI clear is applied first, then the set. If both hit the same bit, the set wins.
- `int_out` is held low from the first INTA edge until IDLE is re-entered.
- Reset values:
  - ISR=0, `lowest`=7, state IDLE, `inta_n_q`=1.
  - `int_out`=0, `clear_ir_line`=0, `data_out`=0, `data_out_en`=0.

## Timing
- `int_out` is registered: it asserts 1 cycle after a valid winner appears in IDLE and deasserts 1 cycle after the winner disappears.
- First INTA falling edge sampled at edge N: ISR bit and `clear_ir_line` are visible after edge N. `clear_ir_line` returns to 0 after edge N+1.
- Second INTA falling edge sampled at edge M: `data_out`/`data_out_en` are valid after edge M. `data_out_en` drops after the edge that samples `inta_n` high.
- The AEOI clear is visible after the same edge that drops `data_out_en`.
- `W` is frozen from the first INTA edge through ACK2; IRR changes in between have no effect.
- Asynchronous reset mid-sequence returns everything to reset values immediately. A later `inta_n` rising edge is ignored; the next falling edge starts a new sequence.

## Test plan
- IRR=`0x28`, mask=0, ISR=0 → `int_out`=1. Two INTA pulses with `vector_base`=`0x08` → ISR=`0x08`, `clear_ir_line`=`0x08` for 1 cycle, `data_out`=`0x43`.
- ISR=`0x04`, IRR=`0x10` → `int_out` stays 0. Then IRR=`0x02` → `int_out`=1, and after acknowledge ISR=`0x06`.
- ISR=`0x06`, non-specific EOI → ISR=`0x04`. With `rotate_en`, `lowest`=1, so IRR=`0x81` now grants IR7 before IR0.
- `auto_eoi`=1, IRR=`0x01`, full INTA sequence → ISR reads `0x01` during GAP and returns to `0x00` after the second INTA rises.
- IRR drops to 0 between `int_out` and the first INTA → ISR unchanged, `clear_ir_line`=0, `data_out`={base,3'b111}.
- `rst_n` pulsed low in GAP → all outputs 0, ISR=0, and the next INTA pair yields a fresh sequence.
